// File: rtl/inst_mem_loader_if.sv
// Loader bus: program-word source handshake, instruction-memory write port
// and core-control/status outputs.
interface inst_mem_loader_if #(parameter int ADDR_WIDTH = 15);
  logic                  start;
  logic [ADDR_WIDTH-1:0] wordCount;
  logic [15:0]           wordIn;
  logic                  wordValid;
  logic                  wordReady;
  logic [ADDR_WIDTH-1:0] imAddr;
  logic [15:0]           imData;
  logic                  imWrite;
  logic                  cpuReset;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (
    output start, wordCount, wordIn, wordValid,
    input  wordReady, imAddr, imData, imWrite, cpuReset, busy, done, error
  );

  modport slave (
    input  start, wordCount, wordIn, wordValid,
    output wordReady, imAddr, imData, imWrite, cpuReset, busy, done, error
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Streams program words into instruction memory with the core held in reset,
// verifies a trailing XOR checksum, then releases the core.
module inst_mem_loader #(
  parameter int ADDR_WIDTH  = 15,
  parameter int HOLD_CYCLES = 2
) (
  input logic              CLK,
  input logic              Reset,
  inst_mem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERROR
  } state_t;

  state_t                r_state, w_state;
  logic [ADDR_WIDTH-1:0] r_remaining, w_remaining;
  logic [ADDR_WIDTH-1:0] r_addr_cnt, w_addr_cnt;
  logic [ADDR_WIDTH-1:0] r_im_addr, w_im_addr;
  logic [15:0]           r_xor, w_xor;
  logic [15:0]           r_im_data, w_im_data;
  logic [3:0]            r_hold, w_hold;
  logic                  r_im_write, w_im_write;
  logic                  r_word_ready, r_cpu_reset, r_busy, r_done, r_error;
  logic                  w_xfer;

  assign w_xfer = bus.wordValid && r_word_ready;

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  always_comb begin
    w_state     = r_state;
    w_remaining = r_remaining;
    w_addr_cnt  = r_addr_cnt;
    w_xor       = r_xor;
    w_hold      = r_hold;
    w_im_addr   = r_im_addr;
    w_im_data   = r_im_data;
    w_im_write  = 1'b0;
    case (r_state)
      S_IDLE, S_ERROR: begin
        if (bus.start) begin
          w_remaining = bus.wordCount;
          w_addr_cnt  = '0;
          w_xor       = '0;
          w_state     = (bus.wordCount != '0) ? S_LOAD : S_CHECK;
        end
      end
      S_LOAD: begin
        if (w_xfer) begin
          w_im_addr   = r_addr_cnt;
          w_im_data   = bus.wordIn;
          w_im_write  = 1'b1;
          w_addr_cnt  = r_addr_cnt + ADDR_WIDTH'(1);
          w_xor       = r_xor ^ bus.wordIn;
          w_remaining = r_remaining - ADDR_WIDTH'(1);
          if (r_remaining == ADDR_WIDTH'(1)) w_state = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_xfer) begin
          if (bus.wordIn == r_xor) begin
            w_hold  = 4'(HOLD_CYCLES);
            w_state = S_HOLD;
          end else begin
            w_state = S_ERROR;
          end
        end
      end
      // Counter runs HOLD_CYCLES..0 and exits on the 0 cycle, so the core
      // sees HOLD_CYCLES+1 cycles of reset after the checksum edge.
      S_HOLD: begin
        if (r_hold == 4'd0) w_state = S_RUN;
        else                w_hold  = r_hold - 4'd1;
      end
      S_RUN:   ;
      default: w_state = S_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_remaining  <= '0;
      r_addr_cnt   <= '0;
      r_xor        <= '0;
      r_hold       <= '0;
      r_im_addr    <= '0;
      r_im_data    <= '0;
      r_im_write   <= 1'b0;
      r_word_ready <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_remaining  <= w_remaining;
      r_addr_cnt   <= w_addr_cnt;
      r_xor        <= w_xor;
      r_hold       <= w_hold;
      r_im_addr    <= w_im_addr;
      r_im_data    <= w_im_data;
      r_im_write   <= w_im_write;
      r_word_ready <= (w_state == S_LOAD) || (w_state == S_CHECK);
      r_cpu_reset  <= (w_state != S_RUN);
      r_busy       <= (w_state == S_LOAD) || (w_state == S_CHECK) || (w_state == S_HOLD);
      r_done       <= (w_state == S_RUN);
      r_error      <= (w_state == S_ERROR);
    end
  end

  assign bus.wordReady = r_word_ready;
  assign bus.imAddr    = r_im_addr;
  assign bus.imData    = r_im_data;
  assign bus.imWrite   = r_im_write;
  assign bus.cpuReset  = r_cpu_reset;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: write log, release latency, error/retry,
// zero-length, mid-load reset and RUN lockout.
module tb_inst_mem_loader;
  localparam int AW = 15;

  logic CLK = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] prog [0:7];
  int          la[$];
  int          ld[$];
  int          lc[$];

  inst_mem_loader_if #(.ADDR_WIDTH(AW)) bus();

  inst_mem_loader #(.ADDR_WIDTH(AW), .HOLD_CYCLES(2)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.imWrite === 1'b1) begin
      la.push_back(int'(bus.imAddr));
      ld.push_back(int'(bus.imData));
      lc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic log_clr();
    la.delete(); ld.delete(); lc.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic start_load(input int cnt);
    bus.start     = 1'b1;
    bus.wordCount = AW'(cnt);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic stream(input int cnt, input logic [15:0] cks, input bit stall);
    int i;
    int guard;
    bit xf;
    i = 0;
    guard = 0;
    while (i <= cnt && guard < 64) begin
      bus.wordValid = !(stall && (guard % 2 == 1));
      bus.wordIn    = (i < cnt) ? prog[i] : cks;
      xf = bus.wordValid && bus.wordReady;
      tick();
      if (xf) i++;
      guard++;
    end
    bus.wordValid = 1'b0;
    chk("stream_xfers", i, cnt + 1);
  endtask

  task automatic wait_release(input int exp);
    int n;
    n = 0;
    while (bus.cpuReset === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("release_lat", n, exp);
    chk("done", bus.done, 1);
    chk("error_low", bus.error, 0);
    chk("busy_low", bus.busy, 0);
  endtask

  initial begin
    Reset = 1'b1;
    bus.start = 1'b0;
    bus.wordCount = '0;
    bus.wordIn = '0;
    bus.wordValid = 1'b0;
    tick();
    tick();
    Reset = 1'b0;

    // reset state
    chk("rst_flags", {bus.wordReady, bus.imWrite, bus.cpuReset, bus.busy, bus.done, bus.error}, 6'b001000);
    chk("rst_addr", bus.imAddr, 0);
    chk("rst_data", bus.imData, 0);

    // basic load
    prog[0] = 16'h1234; prog[1] = 16'h00FF; prog[2] = 16'hA000;
    log_clr();
    start_load(3);
    chk("basic_ready", bus.wordReady, 1);
    chk("basic_busy", bus.busy, 1);
    chk("basic_cpurst", bus.cpuReset, 1);
    stream(3, 16'hB2CB, 1'b0);
    chk("basic_ready_fall", bus.wordReady, 0);
    wait_release(3);
    chk("basic_nwr", la.size(), 3);
    if (la.size() == 3) begin
      chk("basic_a0", la[0], 0);  chk("basic_d0", ld[0], 16'h1234);
      chk("basic_a1", la[1], 1);  chk("basic_d1", ld[1], 16'h00FF);
      chk("basic_a2", la[2], 2);  chk("basic_d2", ld[2], 16'hA000);
      chk("basic_gap01", lc[1] - lc[0], 1);
      chk("basic_gap12", lc[2] - lc[1], 1);
    end

    // stalled source
    do_reset();
    log_clr();
    start_load(3);
    stream(3, 16'hB2CB, 1'b1);
    wait_release(3);
    chk("stall_nwr", la.size(), 3);
    if (la.size() == 3) begin
      chk("stall_a0", la[0], 0);  chk("stall_d0", ld[0], 16'h1234);
      chk("stall_a1", la[1], 1);  chk("stall_d1", ld[1], 16'h00FF);
      chk("stall_a2", la[2], 2);  chk("stall_d2", ld[2], 16'hA000);
      chk("stall_gap01", lc[1] - lc[0], 2);
      chk("stall_gap12", lc[2] - lc[1], 2);
    end

    // bad checksum then retry
    do_reset();
    log_clr();
    start_load(3);
    stream(3, 16'h0000, 1'b0);
    chk("bad_error", bus.error, 1);
    chk("bad_cpurst", bus.cpuReset, 1);
    chk("bad_busy", bus.busy, 0);
    chk("bad_ready", bus.wordReady, 0);
    repeat (4) tick();
    chk("bad_cpurst_hold", bus.cpuReset, 1);
    chk("bad_error_hold", bus.error, 1);
    log_clr();
    prog[0] = 16'h5555;
    start_load(1);
    chk("retry_err_clr", bus.error, 0);
    stream(1, 16'h5555, 1'b0);
    wait_release(3);
    chk("retry_nwr", la.size(), 1);
    if (la.size() == 1) begin
      chk("retry_a0", la[0], 0);
      chk("retry_d0", ld[0], 16'h5555);
    end

    // zero-length load
    do_reset();
    log_clr();
    start_load(0);
    chk("zero_ready", bus.wordReady, 1);
    stream(0, 16'h0000, 1'b0);
    wait_release(3);
    chk("zero_nwr", la.size(), 0);

    // reset mid-load
    do_reset();
    log_clr();
    prog[0] = 16'hC001; prog[1] = 16'hC002; prog[2] = 16'hC003; prog[3] = 16'hC004;
    start_load(4);
    bus.wordValid = 1'b1;
    bus.wordIn = prog[0]; tick();
    bus.wordIn = prog[1]; tick();
    bus.wordIn = prog[2];
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_flags", {bus.wordReady, bus.cpuReset, bus.busy}, 3'b010);
    repeat (3) tick();
    bus.wordValid = 1'b0;
    chk("midrst_nwr", la.size(), 2);
    log_clr();
    prog[0] = 16'hBEEF;
    start_load(1);
    stream(1, 16'hBEEF, 1'b0);
    wait_release(3);
    chk("midrst_new_nwr", la.size(), 1);
    if (la.size() == 1) begin
      chk("midrst_new_a0", la[0], 0);
      chk("midrst_new_d0", ld[0], 16'hBEEF);
    end

    // RUN lockout
    log_clr();
    bus.start = 1'b1;
    bus.wordCount = AW'(2);
    bus.wordValid = 1'b1;
    bus.wordIn = 16'h1111;
    repeat (4) tick();
    bus.start = 1'b0;
    bus.wordValid = 1'b0;
    tick();
    chk("run_nwr", la.size(), 0);
    chk("run_flags", {bus.wordReady, bus.cpuReset, bus.busy, bus.done}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Program loader that streams 16-bit instruction words from an external source into the processor's instruction memory while holding the processor core in reset, then releases it. It drives the instruction-memory write port (address, data, write enable) that the core otherwise leaves idle, and generates the core's `Reset`. Each load is checked with a trailing XOR checksum word. The core only runs after a verified load.

## Interface
Parameters:
- `ADDR_WIDTH`, 15: instruction-memory word-address width; matches the core's `PC[15:1]` indexing.
- `HOLD_CYCLES`, 2: cycles `cpuReset` stays high after a successful checksum; legal range 1..15.

Ports:
- `CLK`, input, 1: system clock; all state changes on the rising edge.
- `Reset`, input, 1: synchronous, active-high; returns the block to IDLE.
- `start`, input, 1: begin a load; sampled in IDLE and ERROR only.
- `wordCount`, input, ADDR_WIDTH: number of program words; sampled on the accepted `start`.
- `wordIn`, input, 16: incoming word (program word or checksum).
- `wordValid`, input, 1: `wordIn` is valid.
- `wordReady`, output, 1: loader accepts `wordIn` this cycle.
- `imAddr`, output, ADDR_WIDTH: instruction-memory write address.
- `imData`, output, 16: instruction-memory write data.
- `imWrite`, output, 1: instruction-memory write enable, one cycle per word.
- `cpuReset`, output, 1: reset to the processor core's `Reset` input.
- `busy`, output, 1: a load or hold is in progress.
- `done`, output, 1: load verified and core released.
- `error`, output, 1: checksum mismatch on the last load.

## Operation
The state machine has six states: IDLE, LOAD, CHECK, HOLD, RUN and ERROR.

- **Handshake.** A word transfers on any cycle where `wordValid && wordReady`. `wordReady` = 1 only in LOAD and CHECK. A word held with `wordValid` high and `wordReady` low is not consumed.
- **IDLE.** `cpuReset`=1. On `start`:
  - capture `wordCount` into `remaining`;
  - clear `addrCnt` and `xorAcc` to 0;
  - go to LOAD if `wordCount` != 0, otherwise go to CHECK.
- **LOAD.** On each transfer:
  - register `imAddr` <= `addrCnt`, `imData` <= `wordIn`, `imWrite` <= 1;
  - `addrCnt` += 1;
  - `xorAcc` ^= `wordIn`;
  - `remaining` -= 1.
  - When the transfer consumes the last word (`remaining` == 1), go to CHECK.
- **CHECK.** The next transfer is the checksum word. It is not written to memory.
  - If `wordIn` == `xorAcc`, load the hold counter with `HOLD_CYCLES` and go to HOLD.
  - Otherwise set `error` and go to ERROR.
- **HOLD.** `cpuReset`=1. Decrement the hold counter each cycle. When it reaches 0, go to RUN.
- **RUN.** `cpuReset`=0, `done`=1. `start` and `wordValid` are ignored. Only `Reset` leaves RUN.
- **ERROR.** `cpuReset`=1, `error`=1. On `start`, re-arm exactly as from IDLE and clear `error`.
- **Arithmetic.** `addrCnt` is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. Since `wordCount` is also ADDR_WIDTH bits, a wrap cannot occur within one load. `xorAcc` is 16 bits.
- **`Reset` mid-operation.** Go to IDLE immediately. Words already written stay in memory. `xorAcc`, `remaining` and `addrCnt` are cleared.
- **Simultaneous `start` and `wordValid` in IDLE.** Only `start` is acted on. The word is not consumed, because `wordReady`=0 in IDLE.

## Timing
- **Reset values:**
  - `wordReady`=0, `imAddr`=0, `imData`=0, `imWrite`=0;
  - `cpuReset`=1, `busy`=0, `done`=0, `error`=0;
  - state = IDLE.
- **Output registers.** All outputs are registered.
  - `wordReady` rises the cycle after `start` is accepted.
  - `wordReady` falls the cycle after the checksum transfer.
- **Write latency.** `imWrite`/`imAddr`/`imData` are valid exactly 1 cycle after each LOAD transfer. Back-to-back transfers give back-to-back writes at a rate of 1 word per cycle.
- **Last word.** The write for the last program word is issued in the first CHECK cycle. A checksum transfer in that same cycle is legal.
- **Release latency.** `cpuReset` falls `HOLD_CYCLES`+1 cycles after the checksum transfer edge. `done` rises in the same cycle `cpuReset` falls.
- **Error latency.** `error` rises 1 cycle after a mismatching checksum transfer.
- **`busy`.** `busy` = 1 in LOAD, CHECK and HOLD; 0 otherwise.

## Test plan
- **Basic load.** Reset, then `start` with `wordCount`=3. Stream 0x1234, 0x00FF, 0xA000 on consecutive cycles, then checksum 0xB2CB.
  - Required: writes at addresses 0/1/2 with those data on 3 consecutive cycles.
  - Required: `cpuReset` falls 3 cycles after the checksum (`HOLD_CYCLES`=2); `done`=1; `error`=0.
- **Stalled source.** Same data with `wordValid` toggling 1,0,1,0.
  - Required: `imWrite` pulses only after valid cycles; addresses are still 0,1,2; no duplicate writes.
- **Bad checksum, then retry.** Checksum 0x0000 for the stream above.
  - Required: `error`=1 and `cpuReset` stays 1.
  - Re-`start` with `wordCount`=1 and word 0x5555, checksum 0x5555. Required: `error` clears; write to address 0 = 0x5555; `done`=1.
- **Zero-length load.** `start` with `wordCount`=0, then checksum 0x0000.
  - Required: no `imWrite` pulse; release after `HOLD_CYCLES`+1 cycles.
- **Reset mid-load.** Assert `Reset` after 2 of 4 words.
  - Required: next cycle `busy`=0, `wordReady`=0, `cpuReset`=1, no further writes.
  - A new 1-word load then writes address 0.
- **RUN lockout.** In RUN, assert `start` with `wordValid`=1.
  - Required: no writes; `cpuReset` stays 0; `done` stays 1.
